// File: rtl/hp_addsub_arbiter_pkg.sv
// Shared types and constants for the half-precision add/sub arbiter.
package hp_addsub_arbiter_pkg;

  localparam int FP_W  = 16;
  localparam int EXC_W = 2;

  localparam logic [FP_W-1:0] POS_ONE = 16'h3C00;
  localparam logic [FP_W-1:0] POS_TWO = 16'h4000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/hp_addsub_arbiter_if.sv
// Request, adder and response signals of the shared fp16 add/sub datapath.
interface hp_addsub_arbiter_if;
  import hp_addsub_arbiter_pkg::*;

  logic             req0_valid;
  logic             req0_ready;
  logic [FP_W-1:0]  req0_a;
  logic [FP_W-1:0]  req0_b;
  logic             req0_op;

  logic             req1_valid;
  logic             req1_ready;
  logic [FP_W-1:0]  req1_a;
  logic [FP_W-1:0]  req1_b;
  logic             req1_op;

  logic [FP_W-1:0]  add_a;
  logic [FP_W-1:0]  add_b;
  logic             add_op;
  logic [FP_W-1:0]  add_sum;
  logic [EXC_W-1:0] add_exc;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [FP_W-1:0]  rsp_sum;
  logic [EXC_W-1:0] rsp_exc;
  logic             rsp_id;
  logic             busy;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  add_sum, add_exc, rsp_ready,
    output req0_ready, req1_ready,
    output add_a, add_b, add_op,
    output rsp_valid, rsp_sum, rsp_exc, rsp_id, busy
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output add_sum, add_exc, rsp_ready,
    input  req0_ready, req1_ready,
    input  add_a, add_b, add_op,
    input  rsp_valid, rsp_sum, rsp_exc, rsp_id, busy
  );

endinterface

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin grant: a lone requester always wins, a tie goes to the pointer.
module rr_arbiter_2 (
  input  logic valid0,
  input  logic valid1,
  input  logic pointer,
  output logic grant0,
  output logic grant1
);

  assign grant0 = valid0 & (~valid1 | ~pointer);
  assign grant1 = valid1 & (~valid0 |  pointer);

endmodule

// File: rtl/hp_addsub_arbiter.sv
// Shares one fp16 add/sub datapath between two requesters; holds operands for LAT cycles.
module hp_addsub_arbiter
  import hp_addsub_arbiter_pkg::*;
#(
  parameter int LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  hp_addsub_arbiter_if.slave bus
);

  // state | meaning
  // IDLE  | arbitrating, ready offered to the granted requester
  // EXEC  | operands held on the adder, counting down settle cycles
  // RESP  | result presented until the consumer takes it

  state_t           state, state_nxt;
  logic             pointer;
  logic [3:0]       counter;
  logic [FP_W-1:0]  a_q, b_q;
  logic             op_q;
  logic [FP_W-1:0]  sum_q;
  logic [EXC_W-1:0] exc_q;
  logic             id_q;
  logic             rsp_valid_q;
  logic             grant0, grant1;
  logic             ready0, ready1, accept;

  rr_arbiter_2 u_arb (
    .valid0  (bus.req0_valid),
    .valid1  (bus.req1_valid),
    .pointer (pointer),
    .grant0  (grant0),
    .grant1  (grant1)
  );

  // Gated by rst so no requester sees a handshake while reset is held.
  assign ready0 = (state == IDLE) & grant0 & ~rst;
  assign ready1 = (state == IDLE) & grant1 & ~rst;
  assign accept = ready0 | ready1;

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.add_a      = a_q;
  assign bus.add_b      = b_q;
  assign bus.add_op     = op_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_sum    = sum_q;
  assign bus.rsp_exc    = exc_q;
  assign bus.rsp_id     = id_q;
  assign bus.busy       = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)         state_nxt = EXEC;
      EXEC:    if (counter == 4'd0) state_nxt = RESP;
      RESP:    if (bus.rsp_ready)  state_nxt = IDLE;
      default:                     state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pointer     <= 1'b0;
      counter     <= 4'd0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= 1'b0;
      id_q        <= 1'b0;
      sum_q       <= '0;
      exc_q       <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_q     <= ready1 ? bus.req1_a  : bus.req0_a;
            b_q     <= ready1 ? bus.req1_b  : bus.req0_b;
            op_q    <= ready1 ? bus.req1_op : bus.req0_op;
            id_q    <= ready1;
            pointer <= ready0;
            counter <= 4'(LAT - 1);
          end
        end
        EXEC: begin
          if (counter == 4'd0) begin
            sum_q       <= bus.add_sum;
            exc_q       <= bus.add_exc;
            rsp_valid_q <= 1'b1;
          end else begin
            counter <= counter - 4'd1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) rsp_valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hp_addsub_arbiter.sv
// Bench for hp_addsub_arbiter: LAT=1 and LAT=3 instances share stimulus, each checked against a timeline model.
module tb_hp_addsub_arbiter;
  import hp_addsub_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid, req0_op, req1_op, rsp_ready;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;

  int checks = 0;
  int errors = 0;

  logic [1:0]       w_r0, w_r1, w_rv, w_busy, w_id, w_op;
  logic [1:0][15:0] w_sum, w_a, w_b;
  logic [1:0][1:0]  w_exc;

  always #5 clk = ~clk;

  // Stand-in adder: a few known fp16 results, anything else a recognisable scramble.
  function automatic logic [17:0] adder_fn(input logic [15:0] a, input logic [15:0] b, input logic op);
    if (a == 16'h3C00 && b == 16'h3C00 && !op) return {2'b00, 16'h4000};
    if (a == 16'h4000 && b == 16'h3C00 &&  op) return {2'b00, 16'h3C00};
    if (a == 16'h7BFF && b == 16'h7BFF && !op) return {2'b01, 16'h7C00};
    return {2'b00, a ^ b ^ {15'd0, op}};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rv(input int idx, input string name);
    int n = 0;
    while (!w_rv[idx] && n < 20) begin
      tick();
      n++;
    end
    chk(name, 32'(w_rv[idx]), 32'd1);
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam int L = (gi == 0) ? 1 : 3;

    hp_addsub_arbiter_if bus ();

    hp_addsub_arbiter #(.LAT(L)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );

    assign bus.req0_valid = req0_valid;
    assign bus.req0_a     = req0_a;
    assign bus.req0_b     = req0_b;
    assign bus.req0_op    = req0_op;
    assign bus.req1_valid = req1_valid;
    assign bus.req1_a     = req1_a;
    assign bus.req1_b     = req1_b;
    assign bus.req1_op    = req1_op;
    assign bus.rsp_ready  = rsp_ready;
    assign {bus.add_exc, bus.add_sum} = adder_fn(bus.add_a, bus.add_b, bus.add_op);

    assign w_r0[gi]   = bus.req0_ready;
    assign w_r1[gi]   = bus.req1_ready;
    assign w_rv[gi]   = bus.rsp_valid;
    assign w_busy[gi] = bus.busy;
    assign w_id[gi]   = bus.rsp_id;
    assign w_op[gi]   = bus.add_op;
    assign w_sum[gi]  = bus.rsp_sum;
    assign w_a[gi]    = bus.add_a;
    assign w_b[gi]    = bus.add_b;
    assign w_exc[gi]  = bus.rsp_exc;

    // Timeline model: one outstanding op, result due L+1 cycles after its grant cycle.
    int          cyc = 0;
    bit          m_has;
    int          m_tg;
    logic [15:0] m_a, m_b;
    logic        m_op, m_id, m_ptr;
    logic        e_r0, e_r1, e_rv;
    logic [17:0] e_res;

    always @(negedge clk) begin
      if (rst) begin
        m_has = 1'b0; m_ptr = 1'b0; m_a = '0; m_b = '0; m_op = 1'b0; m_id = 1'b0;
        chk($sformatf("L%0d rst ready0", L), 32'(bus.req0_ready), 32'd0);
        chk($sformatf("L%0d rst ready1", L), 32'(bus.req1_ready), 32'd0);
        chk($sformatf("L%0d rst rsp_valid", L), 32'(bus.rsp_valid), 32'd0);
        chk($sformatf("L%0d rst busy", L), 32'(bus.busy), 32'd0);
        chk($sformatf("L%0d rst add", L), {15'd0, bus.add_op, bus.add_a ^ bus.add_b}, 32'd0);
        chk($sformatf("L%0d rst rsp", L), {13'd0, bus.rsp_id, bus.rsp_exc, bus.rsp_sum}, 32'd0);
      end else begin
        e_r0 = !m_has && req0_valid && (!req1_valid || !m_ptr);
        e_r1 = !m_has && req1_valid && (!req0_valid ||  m_ptr);
        e_rv = m_has && (cyc >= m_tg + L + 1);
        chk($sformatf("L%0d c%0d ready0", L, cyc), 32'(bus.req0_ready), 32'(e_r0));
        chk($sformatf("L%0d c%0d ready1", L, cyc), 32'(bus.req1_ready), 32'(e_r1));
        chk($sformatf("L%0d c%0d busy", L, cyc), 32'(bus.busy), 32'(m_has));
        chk($sformatf("L%0d c%0d rsp_valid", L, cyc), 32'(bus.rsp_valid), 32'(e_rv));
        chk($sformatf("L%0d c%0d add_a", L, cyc), 32'(bus.add_a), 32'(m_a));
        chk($sformatf("L%0d c%0d add_b", L, cyc), 32'(bus.add_b), 32'(m_b));
        chk($sformatf("L%0d c%0d add_op", L, cyc), 32'(bus.add_op), 32'(m_op));
        if (e_rv) begin
          e_res = adder_fn(m_a, m_b, m_op);
          chk($sformatf("L%0d c%0d rsp_sum", L, cyc), 32'(bus.rsp_sum), 32'(e_res[15:0]));
          chk($sformatf("L%0d c%0d rsp_exc", L, cyc), 32'(bus.rsp_exc), 32'(e_res[17:16]));
          chk($sformatf("L%0d c%0d rsp_id", L, cyc), 32'(bus.rsp_id), 32'(m_id));
        end
        if (e_rv && rsp_ready) begin
          m_has = 1'b0;
        end else if (e_r0 || e_r1) begin
          m_has = 1'b1;
          m_tg  = cyc;
          m_id  = e_r1;
          m_a   = e_r1 ? req1_a  : req0_a;
          m_b   = e_r1 ? req1_b  : req0_b;
          m_op  = e_r1 ? req1_op : req0_op;
          m_ptr = !e_r1;
        end
      end
      cyc++;
    end
  end

  int gid [4];
  int ng;
  int waited;

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; req0_op = 1'b0; req1_op = 1'b0; rsp_ready = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    tick(); tick();
    chk("reset busy", 32'(w_busy), 32'd0);
    chk("reset rsp_valid", 32'(w_rv), 32'd0);
    chk("reset add_a L3", 32'(w_a[1]), 32'd0);
    chk("reset rsp_sum L1", 32'(w_sum[0]), 32'd0);
    rst = 1'b0;

    // Single add, 1.0 + 1.0
    req0_valid = 1'b1; req0_a = POS_ONE; req0_b = POS_ONE; req0_op = 1'b0; rsp_ready = 1'b1;
    #1;
    chk("t1 ready0 L1 cycle0", 32'(w_r0[0]), 32'd1);
    chk("t1 ready0 L3 cycle0", 32'(w_r0[1]), 32'd1);
    tick(); req0_valid = 1'b0;
    tick();
    chk("t1 rsp_valid L1 cycle2", 32'(w_rv[0]), 32'd1);
    chk("t1 rsp_sum L1", 32'(w_sum[0]), 32'h4000);
    chk("t1 rsp_id L1", 32'(w_id[0]), 32'd0);
    chk("t1 rsp_exc L1", 32'(w_exc[0]), 32'd0);
    chk("t1 rsp_valid L3 cycle2", 32'(w_rv[1]), 32'd0);
    tick(); tick();
    chk("t1 rsp_valid L3 cycle4", 32'(w_rv[1]), 32'd1);
    chk("t1 rsp_sum L3", 32'(w_sum[1]), 32'h4000);
    tick();

    // Both requesters hammering 2.0 - 1.0; grants must alternate from 0
    rst = 1'b1; tick(); rst = 1'b0;
    req0_a = POS_TWO; req0_b = POS_ONE; req0_op = 1'b1;
    req1_a = POS_TWO; req1_b = POS_ONE; req1_op = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    ng = 0;
    for (int i = 0; i < 12; i++) begin
      if ((w_r0[0] | w_r1[0]) && ng < 4) begin
        gid[ng] = int'(w_r1[0]);
        ng++;
      end
      tick();
    end
    chk("t2 grant count L1", 32'(ng), 32'd4);
    for (int i = 0; i < 4; i++) chk($sformatf("t2 grant%0d id", i), 32'(gid[i]), 32'(i % 2));
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick(); tick(); tick(); tick(); tick();

    // LAT=3 response stall and operand stability
    rst = 1'b1; tick(); rst = 1'b0;
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = POS_ONE; req0_b = POS_ONE; req0_op = 1'b0;
    tick();
    req0_a = 16'hFFFF; req0_b = 16'hFFFF;
    #1;
    chk("t4 add_a held L3", 32'(w_a[1]), 32'h3C00);
    chk("t4 add_b held L3", 32'(w_b[1]), 32'h3C00);
    waited = 0;
    while (!w_rv[1] && waited < 20) begin
      tick();
      waited++;
    end
    chk("t3 latency L3", 32'(waited), 32'd3);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("t3 stall%0d rsp_valid", i), 32'(w_rv[1]), 32'd1);
      chk($sformatf("t3 stall%0d rsp_sum", i), 32'(w_sum[1]), 32'h4000);
      chk($sformatf("t3 stall%0d ready0", i), 32'(w_r0[1]), 32'd0);
    end
    rsp_ready = 1'b1;
    tick();
    chk("t3 idle after ready busy", 32'(w_busy[1]), 32'd0);
    chk("t3 idle after ready ready0", 32'(w_r0[1]), 32'd1);
    req0_valid = 1'b0;
    for (int i = 0; i < 8; i++) tick();

    // Reset during EXEC cycle 2
    rst = 1'b1; tick(); rst = 1'b0;
    req0_valid = 1'b1; req0_a = POS_ONE; req0_b = POS_ONE; req0_op = 1'b0;
    tick(); req0_valid = 1'b0;
    tick();
    #2 rst = 1'b1;
    #1;
    chk("t5 async busy", 32'(w_busy[1]), 32'd0);
    chk("t5 async add_a", 32'(w_a[1]), 32'd0);
    chk("t5 async add_b", 32'(w_b[1]), 32'd0);
    chk("t5 async rsp_valid", 32'(w_rv[1]), 32'd0);
    tick(); rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("t5 no rsp %0d", i), 32'(w_rv[1]), 32'd0);
    end
    req0_a = POS_TWO; req0_b = POS_ONE; req0_op = 1'b1;
    req1_a = POS_TWO; req1_b = POS_ONE; req1_op = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("t5 pointer reset ready0", 32'(w_r0[1]), 32'd1);
    chk("t5 pointer reset ready1", 32'(w_r1[1]), 32'd0);
    tick(); req0_valid = 1'b0; req1_valid = 1'b0;
    wait_rv(1, "t5 served rsp_valid");
    chk("t5 served rsp_sum", 32'(w_sum[1]), 32'h3C00);
    chk("t5 served rsp_id", 32'(w_id[1]), 32'd0);
    for (int i = 0; i < 4; i++) tick();

    // Exception passthrough from requester 1
    req1_valid = 1'b1; req1_a = 16'h7BFF; req1_b = 16'h7BFF; req1_op = 1'b0;
    tick(); req1_valid = 1'b0;
    wait_rv(0, "t6 rsp_valid L1");
    chk("t6 rsp_sum L1", 32'(w_sum[0]), 32'h7C00);
    chk("t6 rsp_exc L1", 32'(w_exc[0]), 32'd1);
    chk("t6 rsp_id L1", 32'(w_id[0]), 32'd1);
    wait_rv(1, "t6 rsp_valid L3");
    chk("t6 rsp_exc L3", 32'(w_exc[1]), 32'd1);
    for (int i = 0; i < 4; i++) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
